// File: rtl/median_window_sched.sv
// Frame sequencer for the 3x3 binary majority filter: raster walk, 9-tap fetch, vote, write-back.
// Optional MEDIAN_BORDER_COPY_EN: border pixels copy their own source bit instead of writing zero.
module median_window_sched #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_f_nios,
  input  logic              rst_f_nios,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned ColW = $clog2(IMG_W);

  localparam logic [RowW-1:0]   LastRow = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0]   LastCol = ColW'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] TwoRows = ADDR_W'(2 * IMG_W);

`ifdef MEDIAN_BORDER_COPY_EN
  localparam bit BorderCopy = 1'b1;
`else
  localparam bit BorderCopy = 1'b0;
`endif

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StNext  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [3:0]      tap_q, tap_d;
  logic [3:0]      ones_q, ones_d;
  logic            border_q, border_d;
  logic            rd_pend_q;

  logic [ADDR_W-1:0] centre_addr;
  logic [ADDR_W-1:0] win_base;
  logic [ADDR_W-1:0] tap_off;
  logic [3:0]        last_tap;
  logic              last_col;
  logic              last_row;
  logic              enter_pixel;
  logic              vote;

  // Only bit0 of the source byte carries the binary pixel.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[7:1];

  assign centre_addr = ADDR_W'(row_q) * RowStep + ADDR_W'(col_q);
  assign win_base    = centre_addr - RowStep - ADDR_W'(1);
  assign last_col    = (col_q == LastCol);
  assign last_row    = (row_q == LastRow);
  assign last_tap    = border_q ? 4'd0 : 4'd8;

  always_comb begin
    tap_off = '0;
    case (tap_q)
      4'd1:    tap_off = ADDR_W'(1);
      4'd2:    tap_off = ADDR_W'(2);
      4'd3:    tap_off = RowStep;
      4'd4:    tap_off = RowStep + ADDR_W'(1);
      4'd5:    tap_off = RowStep + ADDR_W'(2);
      4'd6:    tap_off = TwoRows;
      4'd7:    tap_off = TwoRows + ADDR_W'(1);
      4'd8:    tap_off = TwoRows + ADDR_W'(2);
      default: tap_off = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tap_d       = tap_q;
    border_d    = border_q;
    enter_pixel = 1'b0;
    // Read data lands one cycle after its strobe; accumulate whenever a read is in flight.
    ones_d      = rd_pend_q ? (ones_q + 4'(rd_data[0])) : ones_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          row_d       = '0;
          col_d       = '0;
          enter_pixel = 1'b1;
        end
      end
      StFetch: begin
        if (tap_q == last_tap) begin
          state_d = StDrain;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        if (wr_ready) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (last_col && last_row) begin
          state_d = StDone;
        end else begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          enter_pixel = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (enter_pixel) begin
      border_d = (row_d == '0) || (row_d == LastRow) || (col_d == '0) || (col_d == LastCol);
      tap_d    = '0;
      ones_d   = '0;
      state_d  = (border_d && !BorderCopy) ? StWrite : StFetch;
    end
  end

  always_ff @(posedge clk_f_nios) begin
    if (!rst_f_nios) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      tap_q     <= '0;
      ones_q    <= '0;
      border_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tap_q     <= tap_d;
      ones_q    <= ones_d;
      border_q  <= border_d;
      rd_pend_q <= (state_q == StFetch);
    end
  end

  // A copied border pixel has at most one sample, so any one wins; interior needs 5 of 9.
  assign vote = border_q ? (BorderCopy && (ones_q != 4'd0)) : (ones_q >= 4'd5);

  always_comb begin
    busy     = (state_q != StIdle) && (state_q != StDone);
    done     = (state_q == StDone);
    rd_en    = (state_q == StFetch);
    rd_addr  = '0;
    wr_valid = (state_q == StWrite);
    wr_addr  = '0;
    wr_data  = 8'h00;
    if (rd_en) begin
      rd_addr = border_q ? centre_addr : (win_base + tap_off);
    end
    if (wr_valid) begin
      wr_addr = centre_addr;
      wr_data = vote ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_median_window_sched.sv
// Directed bench for median_window_sched on a 4x3 frame; expectations come from a window model.
module tb_median_window_sched;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned AW   = 17;
  localparam int unsigned NPIX = W * H;
`ifdef MEDIAN_BORDER_COPY_EN
  localparam int unsigned BorderLat   = 4;
  localparam int unsigned BorderReads = 1;
`else
  localparam int unsigned BorderLat   = 2;
  localparam int unsigned BorderReads = 0;
`endif
  localparam int unsigned FrameLat = (NPIX - 2) * BorderLat + 2 * 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0]    src [0:NPIX-1];
  int            cyc = 0;
  logic [AW-1:0] rd_alog [0:511];
  int            rd_clog [0:511];
  int            rd_n = 0;
  logic [AW-1:0] wr_alog [0:255];
  logic [7:0]    wr_dlog [0:255];
  int            wr_n = 0;
  int            done_n = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median_window_sched #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW)
  ) dut (
    .clk_f_nios(clk),
    .rst_f_nios(rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Source RAM model: data one cycle after the strobe, junk with bit0 set otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= (rd_en && rd_addr < AW'(NPIX)) ? src[rd_addr[3:0]] : 8'h55;
    if (rd_en && rd_n < 512) begin
      rd_alog[rd_n] <= rd_addr;
      rd_clog[rd_n] <= cyc;
      rd_n <= rd_n + 1;
    end
    if (wr_valid && wr_ready && wr_n < 256) begin
      wr_alog[wr_n] <= wr_addr;
      wr_dlog[wr_n] <= wr_data;
      wr_n <= wr_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  function automatic logic [7:0] exp_pix(input int a);
    int r;
    int c;
    int sum;
    r = a / W;
    c = a % W;
    sum = 0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
`ifdef MEDIAN_BORDER_COPY_EN
      return src[a][0] ? 8'hFF : 8'h00;
`else
      return 8'h00;
`endif
    end
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        sum += int'(src[(r + dr) * W + c + dc][0]);
    return (sum >= 5) ? 8'hFF : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  task automatic start_frame(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int d);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    d = cyc;
  endtask

  task automatic check_frame(input string tag, input int wb);
    check({tag, "_nwrites"}, 32'(wr_n - wb), 32'(NPIX));
    for (int i = 0; i < int'(NPIX); i++) begin
      check({tag, "_waddr"}, 32'(wr_alog[wb + i]), 32'(i));
      check({tag, "_wdata"}, 32'(wr_dlog[wb + i]), 32'(exp_pix(i)));
    end
  endtask

  initial begin
    int s;
    int d;
    int wb;
    int rb;
    int db;
    int idx;
    int n;
    int taps [9];
    taps = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    rst_n = 1'b0;
    start = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < int'(NPIX); i++) src[i] = 8'h01;

    // Reset, then idle with no start.
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("idle");
    end

    // Frame A: all ones, full-speed sink.
    wb = wr_n;
    db = done_n;
    start_frame(s);
    wait_done(d);
    check("a_latency", 32'(d - s), 32'(FrameLat));
    tick();
    check("a_done_one_cycle", 32'(done), 32'd0);
    check("a_done_count", 32'(done_n - db), 32'd1);
    check_frame("a", wb);
    check("a_w5", 32'(wr_dlog[wb + 5]), 32'hFF);
    check("a_w0", 32'(wr_dlog[wb]), 32'(BorderReads != 0 ? 8'hFF : 8'h00));

    // Frame B: 4 ones in pixel 5's window (centre 0), read order, stray start ignored.
    for (int i = 0; i < int'(NPIX); i++) src[i] = 8'h00;
    src[0] = 8'h01;
    src[1] = 8'h01;
    src[2] = 8'h01;
    src[4] = 8'h01;
    wb = wr_n;
    rb = rd_n;
    db = done_n;
    start_frame(s);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d);
    check("b_latency", 32'(d - s), 32'(FrameLat));
    tick();
    check("b_done_count", 32'(done_n - db), 32'd1);
    check_frame("b", wb);
    check("b_thr4_w5", 32'(wr_dlog[wb + 5]), 32'h00);
    check("b_nreads", 32'(rd_n - rb), 32'(18 + 10 * BorderReads));
    idx = rb + 5 * int'(BorderReads);
    for (int k = 0; k < 9; k++) begin
      check("b_tap_addr", 32'(rd_alog[idx + k]), 32'(taps[k]));
      check("b_tap_cycle", 32'(rd_clog[idx + k] - rd_clog[idx]), 32'(k));
    end
    check("b_next_fetch_gap", 32'(rd_clog[idx + 9] - rd_clog[idx]), 32'd12);
    check("b_next_fetch_addr", 32'(rd_alog[idx + 9]), 32'd1);

    // Frame C: fifth one makes pixel 5 a majority; stall its write for 5 cycles.
    src[8] = 8'h01;
    wb = wr_n;
    db = done_n;
    start_frame(s);
    n = 0;
    while (!(wr_valid === 1'b1 && wr_addr === AW'(5)) && n < 200) begin
      tick();
      n++;
    end
    check("c_stall_reached", 32'(wr_addr), 32'd5);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      check("c_stall_valid", 32'(wr_valid), 32'd1);
      check("c_stall_addr", 32'(wr_addr), 32'd5);
      check("c_stall_data", 32'(wr_data), 32'hFF);
      check("c_stall_no_read", 32'(rd_en), 32'd0);
    end
    wr_ready = 1'b1;
    tick();
    check("c_accepted", 32'(wr_valid), 32'd0);
    check("c_next_no_read", 32'(rd_en), 32'd0);
    tick();
    check("c_p6_fetch", 32'(rd_en), 32'd1);
    check("c_p6_addr", 32'(rd_addr), 32'd1);
    wait_done(d);
    check("c_latency", 32'(d - s), 32'(FrameLat + 5));
    tick();
    check("c_done_count", 32'(done_n - db), 32'd1);
    check_frame("c", wb);
    check("c_thr5_w5", 32'(wr_dlog[wb + 5]), 32'hFF);

    // Frame D: abort during fetch, then restart from address 0.
    start_frame(s);
    n = 0;
    while (rd_en !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("d_in_fetch", 32'(rd_en), 32'd1);
    rst_n = 1'b0;
    tick();
    check_idle("abort");
    rst_n = 1'b1;
    wb = wr_n;
    rb = rd_n;
    repeat (3) tick();
    check_idle("post_abort");
    check("d_no_writes", 32'(wr_n - wb), 32'd0);
    check("d_no_reads", 32'(rd_n - rb), 32'd0);
    start_frame(s);
    wait_done(d);
    check("d_latency", 32'(d - s), 32'(FrameLat));
    tick();
    check_frame("d", wb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
